kbd_display: RTL

Scancode-consuming display controller sitting between the PS/2 receiver and the eight-digit seven-segment bank on the board top. Decodes PS/2 set-2 make/break/extended sequences, tracks the held key and optional shift state, counts distinct key presses, and drives registered segment outputs. It supersedes the fixed digit-only display path with a parametrised counter width, a letter/space/enter ASCII map, typematic-repeat suppression and a ready/valid input handshake.

---
 rtl/kbd_pkg.sv | 60 ++++++
 rtl/kbd_display_if.sv | 9 +
 rtl/kbd_ascii_map.sv | 65 ++++++
 rtl/kbd_display.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 scancode display controller:
// FSM state encoding, protocol byte constants and the hex glyph table.
package kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_UPD
  } kbd_state_t;

  // Set-2 prefix bytes
  localparam logic [7:0] KC_BRK     = 8'hF0;
  localparam logic [7:0] KC_EXT     = 8'hE0;

  // Keyboard status / acknowledge bytes that carry no key information
  localparam logic [7:0] KC_DISC_00 = 8'h00;
  localparam logic [7:0] KC_DISC_AA = 8'hAA;
  localparam logic [7:0] KC_DISC_EE = 8'hEE;
  localparam logic [7:0] KC_DISC_FA = 8'hFA;
  localparam logic [7:0] KC_DISC_FE = 8'hFE;

  // Left and right shift
  localparam logic [7:0] KC_SHIFT_L = 8'h12;
  localparam logic [7:0] KC_SHIFT_R = 8'h59;

  localparam logic [7:0] ASCII_NONE = 8'hFF;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;

  function automatic logic is_discard(input logic [7:0] c);
    return (c == KC_DISC_00) || (c == KC_DISC_AA) || (c == KC_DISC_EE) ||
           (c == KC_DISC_FA) || (c == KC_DISC_FE);
  endfunction

  // Active-low {dp,g,f,e,d,c,b,a}; dp is always off
  function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/kbd_display_if.sv
// Scancode byte stream from the PS/2 receiver into the display controller.
interface kbd_display_if;
  logic       code_valid;
  logic [7:0] code;
  logic       code_ready;

  modport master (output code_valid, output code, input code_ready);
  modport slave  (input code_valid, input code, output code_ready);
endinterface

// File: rtl/kbd_ascii_map.sv
// Combinational set-2 scancode to ASCII lookup (digits, letters, space,
// enter). Extended codes never map. Shift upper-cases letters only.
module kbd_ascii_map
  import kbd_pkg::*;
(
  input  logic [7:0] i_code,
  input  logic       i_ext,
  input  logic       i_shift,
  output logic [7:0] o_ascii
);

  logic [7:0] w_base;

  // Base (unshifted) character for a non-extended code
  always_comb begin
    w_base = ASCII_NONE;
    if (!i_ext) begin
      case (i_code)
        8'h45: w_base = 8'h30;
        8'h16: w_base = 8'h31;
        8'h1E: w_base = 8'h32;
        8'h26: w_base = 8'h33;
        8'h25: w_base = 8'h34;
        8'h2E: w_base = 8'h35;
        8'h36: w_base = 8'h36;
        8'h3D: w_base = 8'h37;
        8'h3E: w_base = 8'h38;
        8'h46: w_base = 8'h39;
        8'h1C: w_base = "a";
        8'h32: w_base = "b";
        8'h21: w_base = "c";
        8'h23: w_base = "d";
        8'h24: w_base = "e";
        8'h2B: w_base = "f";
        8'h34: w_base = "g";
        8'h33: w_base = "h";
        8'h43: w_base = "i";
        8'h3B: w_base = "j";
        8'h42: w_base = "k";
        8'h4B: w_base = "l";
        8'h3A: w_base = "m";
        8'h31: w_base = "n";
        8'h44: w_base = "o";
        8'h4D: w_base = "p";
        8'h15: w_base = "q";
        8'h2D: w_base = "r";
        8'h1B: w_base = "s";
        8'h2C: w_base = "t";
        8'h3C: w_base = "u";
        8'h2A: w_base = "v";
        8'h1D: w_base = "w";
        8'h22: w_base = "x";
        8'h35: w_base = "y";
        8'h1A: w_base = "z";
        8'h29: w_base = 8'h20;
        8'h5A: w_base = 8'h0D;
        default: w_base = ASCII_NONE;
      endcase
    end
  end

  assign o_ascii = (i_shift && (w_base >= "a") && (w_base <= "z")) ?
                   (w_base - 8'h20) : w_base;

endmodule

// File: rtl/kbd_display.sv
// PS/2 set-2 scancode display controller. Decodes make/break/extended
// sequences, tracks the held key, counts distinct presses and drives a
// registered active-low seven-segment bank.
// Optional shift tracking is compiled in with `define KBD_SHIFT_EN.
module kbd_display
  import kbd_pkg::*;
#(
  parameter  int CNT_W = 16,
  localparam int SEG_N = 4 + CNT_W / 4
)
(
  input  logic                 clk,
  input  logic                 reset,
  kbd_display_if.slave         bus,
  output logic [8*SEG_N-1:0]   seg,
  output logic                 key_held,
  output logic [7:0]           ascii,
  output logic [CNT_W-1:0]     press_cnt,
  output logic                 cnt_wrap
);

  kbd_state_t       r_state;
  logic             r_ready;
  logic [7:0]       r_evt_code;
  logic             r_evt_ext;
  logic             r_evt_brk;
  logic [7:0]       r_last_code;
  logic             r_last_ext;
  logic             r_key_held;
  logic [7:0]       r_ascii;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wrap;

  logic             w_accept;
  logic             w_match;
  logic             w_is_shift;
  logic             w_shift;
  logic [7:0]       w_map_ascii;

  // Ready is forced low while reset is asserted so nothing is handed over
  // during reset; r_ready itself only drops for the UPD cycle.
  assign bus.code_ready = r_ready & ~reset;
  assign w_accept       = bus.code_valid & bus.code_ready;
  assign w_match        = (r_evt_code == r_last_code) && (r_evt_ext == r_last_ext);

`ifdef KBD_SHIFT_EN
  logic r_shift;
  assign w_is_shift = !r_evt_ext && ((r_evt_code == KC_SHIFT_L) || (r_evt_code == KC_SHIFT_R));
  assign w_shift    = r_shift;
`else
  assign w_is_shift = 1'b0;
  assign w_shift    = 1'b0;
`endif

  kbd_ascii_map u_map (
    .i_code  (r_evt_code),
    .i_ext   (r_evt_ext),
    .i_shift (w_shift),
    .o_ascii (w_map_ascii)
  );

  // Sequence decoder: latches the terminal byte as an event, applies it in UPD
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b1;
      r_evt_code  <= 8'h00;
      r_evt_ext   <= 1'b0;
      r_evt_brk   <= 1'b0;
      r_last_code <= 8'h00;
      r_last_ext  <= 1'b0;
      r_key_held  <= 1'b0;
      r_ascii     <= ASCII_NONE;
      r_cnt       <= '0;
      r_wrap      <= 1'b0;
`ifdef KBD_SHIFT_EN
      r_shift     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (bus.code == KC_BRK) begin
              r_state <= ST_BRK;
            end else if (bus.code == KC_EXT) begin
              r_state <= ST_EXT;
            end else if (!is_discard(bus.code)) begin
              r_evt_code <= bus.code;
              r_evt_ext  <= 1'b0;
              r_evt_brk  <= 1'b0;
              r_state    <= ST_UPD;
              r_ready    <= 1'b0;
            end
          end
        end
        ST_EXT: begin
          if (w_accept) begin
            if (bus.code == KC_BRK) begin
              r_state <= ST_EXT_BRK;
            end else begin
              r_evt_code <= bus.code;
              r_evt_ext  <= 1'b1;
              r_evt_brk  <= 1'b0;
              r_state    <= ST_UPD;
              r_ready    <= 1'b0;
            end
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          if (w_accept) begin
            r_evt_code <= bus.code;
            r_evt_ext  <= (r_state == ST_EXT_BRK);
            r_evt_brk  <= 1'b1;
            r_state    <= ST_UPD;
            r_ready    <= 1'b0;
          end
        end
        ST_UPD: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          if (w_is_shift) begin
`ifdef KBD_SHIFT_EN
            r_shift <= !r_evt_brk;
`endif
          end else if (!r_evt_brk) begin
            // A make of the key already held is typematic repeat
            if (!(r_key_held && w_match)) begin
              r_last_code <= r_evt_code;
              r_last_ext  <= r_evt_ext;
              r_key_held  <= 1'b1;
              r_ascii     <= w_map_ascii;
              r_cnt       <= r_cnt + 1'b1;
              if (&r_cnt) begin
                r_wrap <= 1'b1;
              end
            end
          end else if (w_match) begin
            r_key_held <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign key_held  = r_key_held;
  assign ascii     = r_ascii;
  assign press_cnt = r_cnt;
  assign cnt_wrap  = r_wrap;

  // One registered glyph per digit: 0,1 = last code, 2,3 = ascii, rest = counter
  for (genvar gi = 0; gi < SEG_N; gi++) begin : g_digit
    localparam logic [7:0] RST_GLYPH = (gi < 4) ? SEG_BLANK : 8'hC0;
    logic [7:0] r_digit;
    logic [3:0] w_nib;
    logic       w_lit;

    if (gi < 2) begin : g_code
      assign w_nib = r_last_code[4*gi +: 4];
      assign w_lit = r_key_held;
    end else if (gi < 4) begin : g_ascii
      assign w_nib = r_ascii[4*gi-8 +: 4];
      assign w_lit = r_key_held;
    end else begin : g_cnt
      assign w_nib = r_cnt[4*gi-16 +: 4];
      assign w_lit = 1'b1;
    end

    // Key digits blank when no key is held; counter digits always lit
    always_ff @(posedge clk) begin
      if (reset) begin
        r_digit <= RST_GLYPH;
      end else begin
        r_digit <= w_lit ? hex_to_seg(w_nib) : SEG_BLANK;
      end
    end

    assign seg[8*gi +: 8] = r_digit;
  end

endmodule
